// File: rtl/aes_pkg.sv
// Shared types and constants for the AES3 transmit scheduler.
package aes_pkg;

   localparam int SAMPLE_W      = 24;
   localparam int SUBFRAME_BITS = 64;
   localparam int FRAME_BITS    = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } aes_state_e;

   typedef struct packed {
      logic [SAMPLE_W-1:0] a;
      logic [SAMPLE_W-1:0] b;
   } sample_pair_t;

   // Saturating increment used by the underrun event counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/aes_sample_fifo.sv
// Synchronous FIFO with registered occupancy and full/empty flags.
// A pop on an empty FIFO is ignored, so a same-cycle push into an empty
// FIFO is never bypassed to the read side.
module aes_sample_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full_s    = (level_r == LW'(DEPTH));
   assign empty_s   = (level_r == {LW{1'b0}});
   assign push_ok_s = push && !full_s;
   assign pop_ok_s  = pop && !empty_s;

   assign dout  = mem_r[rd_ptr_r];
   assign level = level_r;
   assign full  = full_s;
   assign empty = empty_s;

   // Storage write; the array itself needs no reset since level gates reads.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {LW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/aes_tx_scheduler.sv
// AES3 transmit scheduler: buffers upstream stereo samples, generates the
// bit-rate shift enable and hands a fresh pair to the transmitter per frame.
module aes_tx_scheduler
   import aes_pkg::*;
#(
   parameter int DIV              = 1,
   parameter int FIFO_DEPTH       = 4,
   parameter int PRIME            = 2,
   parameter int MUTE_ON_UNDERRUN = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [SAMPLE_W-1:0]           in_a,
   input  logic [SAMPLE_W-1:0]           in_b,
   input  logic                          frame_sync,
   output logic                          shift_en,
   output logic [SAMPLE_W-1:0]           channel_a,
   output logic [SAMPLE_W-1:0]           channel_b,
   output logic                          running,
   output logic                          underrun,
   output logic [15:0]                   underrun_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   aes_state_e          state_r;
   aes_state_e          state_nxt_s;
   logic [CW-1:0]       div_cnt_r;
   logic                tick_s;
   logic                pop_s;
   logic                push_s;
   logic                shift_en_s;
   logic                underrun_s;
   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [LW-1:0]       level_s;
   sample_pair_t        head_s;
   sample_pair_t        wr_pair_s;
   logic [SAMPLE_W-1:0] channel_a_r;
   logic [SAMPLE_W-1:0] channel_b_r;
   logic                underrun_r;
   logic [15:0]         underrun_count_r;

   assign wr_pair_s = '{a: in_a, b: in_b};
   assign push_s    = in_valid && !fifo_full_s;
   assign tick_s    = (div_cnt_r == CW'(DIV - 1));
   assign underrun_s = pop_s && fifo_empty_s;

   aes_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(sample_pair_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   (wr_pair_s),
      .dout  (head_s),
      .level (level_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, pop request and shift enable; the DRAIN frame_sync cycle
   // suppresses the shift so the transmitter parks at the next frame start.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      shift_en_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable && (level_s >= LW'(PRIME))) begin
               state_nxt_s = RUN;
               pop_s       = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            shift_en_s = tick_s;
            pop_s      = frame_sync;
            if (!enable) begin
               state_nxt_s = DRAIN;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DRAIN: begin
            if (frame_sync) begin
               state_nxt_s = IDLE;
               shift_en_s  = 1'b0;
            end else if (enable) begin
               state_nxt_s = RUN;
               shift_en_s  = tick_s;
            end else begin
               state_nxt_s = DRAIN;
               shift_en_s  = tick_s;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Bit-rate divider; held at zero while idle so a start is phase-aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r <= {CW{1'b0}};
      end else if (state_r == IDLE) begin
         div_cnt_r <= {CW{1'b0}};
      end else if (tick_s) begin
         div_cnt_r <= {CW{1'b0}};
      end else begin
         div_cnt_r <= div_cnt_r + CW'(1);
      end
   end

   // Channel registers load the FIFO head on a pop; on underrun they mute or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         channel_a_r <= {SAMPLE_W{1'b0}};
         channel_b_r <= {SAMPLE_W{1'b0}};
      end else if (pop_s && !fifo_empty_s) begin
         channel_a_r <= head_s.a;
         channel_b_r <= head_s.b;
      end else if (underrun_s && (MUTE_ON_UNDERRUN != 0)) begin
         channel_a_r <= {SAMPLE_W{1'b0}};
         channel_b_r <= {SAMPLE_W{1'b0}};
      end else begin
         channel_a_r <= channel_a_r;
         channel_b_r <= channel_b_r;
      end
   end

   // Underrun pulse and saturating event counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_r       <= 1'b0;
         underrun_count_r <= 16'd0;
      end else begin
         underrun_r <= underrun_s;
         if (underrun_s) begin
            underrun_count_r <= sat_inc16(underrun_count_r);
         end
      end
   end

   assign in_ready       = !fifo_full_s;
   assign fifo_level     = level_s;
   assign shift_en       = shift_en_s;
   assign running        = (state_r != IDLE);
   assign channel_a      = channel_a_r;
   assign channel_b      = channel_b_r;
   assign underrun       = underrun_r;
   assign underrun_count = underrun_count_r;

endmodule

// File: tb/tb_aes_tx_scheduler.sv
// Scoreboard bench for aes_tx_scheduler: stimulus queues expected values
// tagged with the cycle they are due; a negedge monitor compares them.
module tb_aes_tx_scheduler;

   localparam int SEL_CHA  = 0;
   localparam int SEL_CHB  = 1;
   localparam int SEL_RUN  = 2;
   localparam int SEL_UND  = 3;
   localparam int SEL_UCNT = 4;
   localparam int SEL_LVL  = 5;
   localparam int SEL_RDY  = 6;
   localparam int SEL_SHEN = 7;
   localparam int D4       = 16;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
      string       name;
   } chk_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   chk_t        sbq[$];

   logic        enable = 1'b0, in_valid = 1'b0, frame_sync = 1'b0;
   logic [23:0] in_a = 24'd0, in_b = 24'd0;
   logic        in_ready, shift_en, running, underrun;
   logic [23:0] channel_a, channel_b;
   logic [15:0] underrun_count;
   logic [2:0]  fifo_level;

   logic        enable4 = 1'b0, in_valid4 = 1'b0, frame_sync4 = 1'b0;
   logic [23:0] in_a4 = 24'd0, in_b4 = 24'd0;
   logic        in_ready4, shift_en4, running4, underrun4;
   logic [23:0] channel_a4, channel_b4;
   logic [15:0] underrun_count4;
   logic [2:0]  fifo_level4;

   aes_tx_scheduler #(.DIV(1), .FIFO_DEPTH(4), .PRIME(2), .MUTE_ON_UNDERRUN(0)) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .frame_sync(frame_sync), .shift_en(shift_en),
      .channel_a(channel_a), .channel_b(channel_b), .running(running),
      .underrun(underrun), .underrun_count(underrun_count), .fifo_level(fifo_level)
   );

   aes_tx_scheduler #(.DIV(4), .FIFO_DEPTH(4), .PRIME(1), .MUTE_ON_UNDERRUN(1)) dut4 (
      .clk(clk), .rst(rst), .enable(enable4), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_a(in_a4), .in_b(in_b4), .frame_sync(frame_sync4), .shift_en(shift_en4),
      .channel_a(channel_a4), .channel_b(channel_b4), .running(running4),
      .underrun(underrun4), .underrun_count(underrun_count4), .fifo_level(fifo_level4)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle index used to schedule expectations.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         SEL_CHA:       return {8'd0, channel_a};
         SEL_CHB:       return {8'd0, channel_b};
         SEL_RUN:       return {31'd0, running};
         SEL_UND:       return {31'd0, underrun};
         SEL_UCNT:      return {16'd0, underrun_count};
         SEL_LVL:       return {29'd0, fifo_level};
         SEL_RDY:       return {31'd0, in_ready};
         SEL_SHEN:      return {31'd0, shift_en};
         D4 + SEL_CHA:  return {8'd0, channel_a4};
         D4 + SEL_CHB:  return {8'd0, channel_b4};
         D4 + SEL_RUN:  return {31'd0, running4};
         D4 + SEL_UND:  return {31'd0, underrun4};
         D4 + SEL_UCNT: return {16'd0, underrun_count4};
         D4 + SEL_LVL:  return {29'd0, fifo_level4};
         D4 + SEL_SHEN: return {31'd0, shift_en4};
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic expect_v(input int d, input int sel, input logic [31:0] v, input string nm);
      chk_t e;
      e.cyc  = cyc + d;
      e.sel  = sel;
      e.exp  = v;
      e.name = nm;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every expectation that falls due in this cycle.
   always @(negedge clk) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].cyc == cyc) begin
            logic [31:0] act;
            act = sample(sbq[i].sel);
            checks++;
            if (act !== sbq[i].exp) begin
               failures++;
               $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                        sbq[i].name, act, sbq[i].exp, cyc);
            end
            sbq.delete(i);
         end
      end
   end

   task automatic expect_reset(input int d, input string tag);
      expect_v(d, SEL_CHA, 32'h0, {tag, "_cha"});
      expect_v(d, SEL_CHB, 32'h0, {tag, "_chb"});
      expect_v(d, SEL_RUN, 32'h0, {tag, "_running"});
      expect_v(d, SEL_UND, 32'h0, {tag, "_underrun"});
      expect_v(d, SEL_UCNT, 32'h0, {tag, "_ucnt"});
      expect_v(d, SEL_LVL, 32'h0, {tag, "_level"});
      expect_v(d, SEL_RDY, 32'h1, {tag, "_ready"});
      expect_v(d, SEL_SHEN, 32'h0, {tag, "_shen"});
   endtask

   initial begin
      step();
      step();
      rst = 1'b0;
      expect_reset(0, "reset");
      expect_v(0, D4 + SEL_SHEN, 32'h0, "reset4_shen");

      // Start and sequencing.
      in_valid = 1'b1; in_a = 24'h111111; in_b = 24'h222222;
      step();
      in_a = 24'h333333; in_b = 24'h444444;
      step();
      in_valid = 1'b0;
      checks++;
      if (fifo_level !== 3'd2) begin
         failures++;
         $display("FAIL direct_prime_level: got %0d expected 2", fifo_level);
      end
      expect_v(0, SEL_LVL, 32'd2, "prime_level");
      expect_v(0, SEL_RUN, 32'd0, "idle_before_enable");
      expect_v(0, SEL_SHEN, 32'd0, "idle_shen");
      enable = 1'b1;
      expect_v(1, SEL_RUN, 32'd1, "start_running");
      expect_v(1, SEL_CHA, 32'h111111, "start_cha");
      expect_v(1, SEL_CHB, 32'h222222, "start_chb");
      expect_v(1, SEL_LVL, 32'd1, "start_level");
      step();
      checks++;
      if (running !== 1'b1) begin
         failures++;
         $display("FAIL direct_start_running: got %0b expected 1", running);
      end
      checks++;
      if (channel_a !== 24'h111111) begin
         failures++;
         $display("FAIL direct_start_cha: got %0h expected 111111", channel_a);
      end
      for (int k = 0; k < 5; k++) begin
         expect_v(0, SEL_SHEN, 32'd1, "run_shen");
         step();
      end
      frame_sync = 1'b1;
      expect_v(0, SEL_SHEN, 32'd1, "run_shen_fs");
      expect_v(1, SEL_CHA, 32'h333333, "second_cha");
      expect_v(1, SEL_CHB, 32'h444444, "second_chb");
      expect_v(1, SEL_LVL, 32'd0, "second_level");
      expect_v(1, SEL_UND, 32'd0, "second_no_underrun");
      step();
      frame_sync = 1'b0;
      step();
      step();

      // Underrun with a same-cycle push into the empty FIFO (no bypass).
      frame_sync = 1'b1;
      in_valid = 1'b1; in_a = 24'h555555; in_b = 24'h666666;
      expect_v(1, SEL_UND, 32'd1, "underrun_pulse");
      expect_v(1, SEL_UCNT, 32'd1, "underrun_count");
      expect_v(1, SEL_CHA, 32'h333333, "underrun_hold_a");
      expect_v(1, SEL_CHB, 32'h444444, "underrun_hold_b");
      expect_v(1, SEL_LVL, 32'd1, "underrun_push_level");
      expect_v(2, SEL_UND, 32'd0, "underrun_one_cycle");
      step();
      frame_sync = 1'b0;
      in_a = 24'h777777; in_b = 24'h888888;
      step();
      in_valid = 1'b0;
      expect_v(0, SEL_LVL, 32'd2, "refill_level");
      step();

      // Stop at frame boundary.
      frame_sync = 1'b1;
      expect_v(1, SEL_CHA, 32'h555555, "third_cha");
      expect_v(1, SEL_LVL, 32'd1, "third_level");
      step();
      frame_sync = 1'b0;
      for (int b = 0; b < 127; b++) begin
         if (b == 20) enable = 1'b0;
         if (b == 50) expect_v(0, SEL_RUN, 32'd1, "running_in_drain");
         expect_v(0, SEL_SHEN, 32'd1, "drain_shen");
         step();
      end
      frame_sync = 1'b1;
      expect_v(0, SEL_SHEN, 32'd0, "shen_gated_fs");
      expect_v(1, SEL_RUN, 32'd0, "stop_idle");
      expect_v(1, SEL_SHEN, 32'd0, "stop_shen");
      expect_v(1, SEL_LVL, 32'd1, "stop_no_pop");
      expect_v(1, SEL_CHA, 32'h555555, "stop_cha_kept");
      step();
      frame_sync = 1'b0;
      step();
      frame_sync = 1'b1;
      expect_v(1, SEL_LVL, 32'd1, "idle_fs_no_pop");
      expect_v(1, SEL_UCNT, 32'd1, "idle_fs_no_underrun");
      step();
      frame_sync = 1'b0;

      // Reset mid-RUN with three pairs queued.
      in_valid = 1'b1; in_a = 24'h999999; in_b = 24'hAAAAAA;
      step();
      in_a = 24'hBBBBBB; in_b = 24'hCCCCCC;
      step();
      in_valid = 1'b0;
      enable = 1'b1;
      expect_v(1, SEL_CHA, 32'h777777, "restart_cha");
      expect_v(1, SEL_LVL, 32'd2, "restart_level");
      step();
      in_valid = 1'b1; in_a = 24'hDDDDDD; in_b = 24'hEEEEEE;
      step();
      in_valid = 1'b0;
      expect_v(0, SEL_LVL, 32'd3, "pre_reset_level");
      expect_v(0, SEL_RUN, 32'd1, "pre_reset_running");
      rst = 1'b1;
      enable = 1'b0;
      expect_reset(1, "midrun_reset");
      step();
      checks++;
      if (underrun_count !== 16'd0) begin
         failures++;
         $display("FAIL direct_reset_ucnt: got %0h expected 0", underrun_count);
      end
      checks++;
      if (fifo_level !== 3'd0) begin
         failures++;
         $display("FAIL direct_reset_level: got %0d expected 0", fifo_level);
      end
      rst = 1'b0;

      // Full: five pushes into a depth-4 FIFO.
      in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         in_a = 24'hF00000 + 24'(k);
         in_b = 24'h0F0000 + 24'(k);
         if (k <= 3) expect_v(1, SEL_RDY, 32'd1, "ready_before_full");
         if (k == 4) expect_v(1, SEL_RDY, 32'd0, "ready_low_full");
         if (k == 5) expect_v(0, SEL_RDY, 32'd0, "ready_low_5th");
         if (k >= 4) expect_v(1, SEL_LVL, 32'd4, "full_level");
         step();
      end
      in_valid = 1'b0;
      enable = 1'b1;
      expect_v(1, SEL_CHA, 32'hF00001, "full_pop1_a");
      expect_v(1, SEL_LVL, 32'd3, "full_pop1_level");
      expect_v(1, SEL_RDY, 32'd1, "ready_after_pop");
      step();
      for (int k = 2; k <= 4; k++) begin
         step();
         frame_sync = 1'b1;
         expect_v(1, SEL_CHA, 32'hF00000 + 32'(k), "full_pop_a");
         expect_v(1, SEL_CHB, 32'h0F0000 + 32'(k), "full_pop_b");
         step();
         frame_sync = 1'b0;
      end
      step();
      frame_sync = 1'b1;
      expect_v(1, SEL_UND, 32'd1, "fifth_not_stored");
      expect_v(1, SEL_CHA, 32'hF00004, "hold_not_5th");
      step();
      frame_sync = 1'b0;
      enable = 1'b0;
      step();
      frame_sync = 1'b1;
      step();
      frame_sync = 1'b0;

      // Divider with DIV=4, mute on underrun.
      in_valid4 = 1'b1; in_a4 = 24'hABCDEF; in_b4 = 24'h123456;
      step();
      in_valid4 = 1'b0;
      enable4 = 1'b1;
      expect_v(1, D4 + SEL_RUN, 32'd1, "div4_running");
      expect_v(1, D4 + SEL_CHA, 32'hABCDEF, "div4_cha");
      step();
      for (int k = 0; k < 511; k++) begin
         expect_v(0, D4 + SEL_SHEN, ((k % 4) == 3) ? 32'd1 : 32'd0, "div4_shen");
         step();
      end
      frame_sync4 = 1'b1;
      expect_v(0, D4 + SEL_SHEN, 32'd1, "div4_tick_at_fs");
      expect_v(1, D4 + SEL_UND, 32'd1, "mute_underrun");
      expect_v(1, D4 + SEL_CHA, 32'd0, "mute_a");
      expect_v(1, D4 + SEL_CHB, 32'd0, "mute_b");
      expect_v(1, D4 + SEL_UCNT, 32'd1, "mute_ucnt");
      step();
      frame_sync4 = 1'b0;
      enable4 = 1'b0;
      expect_v(0, D4 + SEL_SHEN, 32'd0, "div4_after_fs");
      step();
      expect_v(0, D4 + SEL_SHEN, 32'd0, "div4_drain_off1");
      step();
      expect_v(0, D4 + SEL_SHEN, 32'd0, "div4_drain_off2");
      step();
      frame_sync4 = 1'b1;
      expect_v(0, D4 + SEL_SHEN, 32'd0, "div4_drain_gate");
      expect_v(1, D4 + SEL_RUN, 32'd0, "div4_stop_idle");
      expect_v(1, D4 + SEL_LVL, 32'd0, "div4_stop_level");
      step();
      frame_sync4 = 1'b0;

      repeat (4) step();
      @(negedge clk);
      #1;
      foreach (sbq[i]) begin
         checks++;
         failures++;
         $display("FAIL %s: never compared (due cycle %0d, now %0d)", sbq[i].name, sbq[i].cyc, cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_tx_scheduler.md
# aes_tx_scheduler

Sequencer and sample buffer that drives the AES3 transmitter. It accepts stereo 24-bit samples from upstream over a valid/ready handshake and buffers them in a small FIFO. It generates the transmitter's bit-rate `shift_en` from the system clock and presents a new sample pair on each transmitter `frame_sync`. It also handles start, stop at a frame boundary, and underrun.

## Interface
- `DIV`, 1: clk cycles per AES bit (biphase half-cell); must be ≥1.
- `FIFO_DEPTH`, 4: sample-pair FIFO entries; power of 2, ≥2.
- `PRIME`, 2: minimum FIFO level required to leave IDLE; 1..FIFO_DEPTH.
- `MUTE_ON_UNDERRUN`, 0: 1 = emit zeros on underrun; 0 = repeat the last pair.
- `clk` in 1: system clock; one clock domain only.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: request to transmit.
- `in_valid` in 1: upstream sample pair valid.
- `in_ready` out 1: FIFO can accept a pair; equals !full.
- `in_a` in 24: upstream channel A sample.
- `in_b` in 24: upstream channel B sample.
- `frame_sync` in 1: transmitter end-of-frame pulse.
- `shift_en` out 1: transmitter shift enable.
- `channel_a` out 24: to transmitter channel A.
- `channel_b` out 24: to transmitter channel B.
- `running` out 1: state ≠ IDLE.
- `underrun` out 1: one-cycle pulse on a pop from an empty FIFO.
- `underrun_count` out 16: saturating underrun counter.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- Push: a pair is written on `in_valid && in_ready`. Writes while full are impossible by construction.
- Pop: reads the head into the `channel_a`/`channel_b` registers.
- Push and pop in the same cycle:
  - Allowed.
  - Level is unchanged.
  - No bypass path: if the FIFO is empty, the pop is an underrun even when a push occurs in that cycle.
- FSM states:
  - IDLE: `shift_en` = 0. Moves to RUN when `enable && fifo_level >= PRIME`, popping one pair on the same edge.
  - RUN: `shift_en` pulses at the bit rate. Each `frame_sync` pops the next pair. If `enable` = 0, move to DRAIN.
  - DRAIN: `shift_en` continues. `enable` = 1 returns to RUN. When `frame_sync` arrives, go to IDLE with no pop.
- Frame boundary stop: on the DRAIN `frame_sync` cycle, `shift_en` is gated off combinationally. The transmitter therefore freezes at the start of channel A of the next frame, which is the aligned point for the next start.
- Underrun (pop with level 0):
  - Channel registers are set to zero if `MUTE_ON_UNDERRUN` = 1, otherwise they are held.
  - `underrun` pulses.
  - `underrun_count` increments and saturates at 0xFFFF.
- `frame_sync` in IDLE is ignored.

## Timing
- Reset values:
  - `shift_en` = 0, `channel_a` = `channel_b` = 0, `running` = 0, `underrun` = 0, `underrun_count` = 0.
  - FIFO is empty: `fifo_level` = 0, `in_ready` = 1.
  - Divider counter = 0, state = IDLE.
- Divider:
  - Counter runs 0..DIV-1 only outside IDLE and clears to 0 in IDLE.
  - tick = (count == DIV-1); `shift_en` = tick && state ≠ IDLE && !(state == DRAIN && `frame_sync`).
  - With DIV = 1, `shift_en` is high every cycle from the first cycle after entering RUN.
- Channel register hold: registers update one cycle after the `frame_sync` cycle or the IDLE→RUN edge, and are otherwise stable. The transmitter latches at bit position 7 of each subframe, so there is ≥6 bit times of margin.
- `fifo_level` and `in_ready` are registered and reflect push/pop on the following cycle.
- `rst` mid-frame:
  - Returns to IDLE and applies the reset values next cycle.
  - The transmitter has no reset and stays frozen mid-frame.
  - On restart, the remainder of that frame carries the freshly popped pair. Alignment is recovered at the next `frame_sync`.

## Structure
- Package `aes_pkg`:
  - `SAMPLE_W` = 24, `SUBFRAME_BITS` = 64, `FRAME_BITS` = 128.
  - State enum IDLE/RUN/DRAIN.
  - `sample_pair_t` = {a, b}, 48 bits.
- Sub-module `aes_sample_fifo`: synchronous FIFO parameterized by depth and width, with level output and full/empty flags.
- The FSM, divider and underrun logic live in the top level.

## Test plan
- **Start and sequencing.** DIV = 1, PRIME = 2. Push 0x111111/0x222222 and 0x333333/0x444444, then raise `enable`.
  - Next cycle: `running` = 1, channel regs = first pair, `shift_en` high continuously.
  - One cycle after the first `frame_sync`: second pair, level 0.
- **Underrun.** One pair pushed, `enable` held.
  - At the first `frame_sync`: `underrun` pulses and `underrun_count` = 1.
  - Channels hold the pair (MUTE = 0) or read 0 (MUTE = 1).
- **Full.** Push 5 pairs in IDLE with depth 4 → `in_ready` low after the 4th, `fifo_level` = 4, 5th pair not accepted.
- **Stop at frame boundary.** Drop `enable` at bit 20 of a frame, DIV = 1.
  - `shift_en` stays high through bit 127, is low in the `frame_sync` cycle, then state is IDLE.
  - No pop; level unchanged.
- **Divider.** DIV = 4 → `shift_en` high exactly one cycle in every 4; 512 clk cycles between `frame_sync` pulses.
- **Reset mid-RUN.** Assert `rst` mid-RUN with 3 pairs queued → next cycle: all outputs at reset values, level 0, `underrun_count` = 0.
